// File: rtl/skinny_isbox8_dom1_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : skinny_dom1_pkg
// Purpose  : Shared definitions for the masked SKINNY inverse 8-bit S-box:
//            network depth, controller state encoding and unmasked reference
//            functions for the forward and inverse S-box.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package skinny_dom1_pkg;

    // Number of gadget layers in the inverse network. Each layer adds one
    // register stage to the settle path.
    localparam int ISBOX8_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic nor2(input logic a, input logic b);
        return ~(a | b);
    endfunction

    // Unmasked S8^-1, one line per gadget of the masked network.
    function automatic logic [7:0] skinny_isbox8_ref(input logic [7:0] y);
        logic [7:0] b;
        b    = '0;
        b[2] = y[0] ^ nor2(y[3], y[1]);
        b[3] = y[4] ^ nor2(y[7], y[6]);
        b[7] = y[1] ^ nor2(y[2], y[7]);
        b[5] = y[7] ^ nor2(y[6], y[5]);
        b[1] = y[3] ^ nor2(y[5], b[3]);
        b[0] = y[5] ^ nor2(b[3], b[2]);
        b[6] = y[2] ^ nor2(b[2], b[1]);
        b[4] = y[6] ^ nor2(b[7], b[6]);
        return b;
    endfunction

    // Unmasked S8, obtained by undoing the inverse layers in reverse order.
    function automatic logic [7:0] skinny_sbox8_ref(input logic [7:0] b);
        logic [7:0] y;
        y    = '0;
        y[6] = b[4] ^ nor2(b[7], b[6]);
        y[2] = b[6] ^ nor2(b[2], b[1]);
        y[5] = b[0] ^ nor2(b[3], b[2]);
        y[3] = b[1] ^ nor2(y[5], b[3]);
        y[7] = b[5] ^ nor2(y[6], y[5]);
        y[1] = b[7] ^ nor2(y[2], y[7]);
        y[4] = b[3] ^ nor2(y[7], y[6]);
        y[0] = b[2] ^ nor2(y[3], y[1]);
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skinny_isbox8_dom1_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : skinny_isbox8_dom1_ctrl_if
// Purpose  : Valid/ready bus of the masked inverse S-box: input share pair
//            with fresh mask, and the masked output share pair.
// Signals  : valid_i/ready_o/si0/si1/r  - input side (producer -> block)
//            valid_o/ready_i/bo0/bo1    - output side (block -> consumer)
// Modports : master (producer/consumer side), slave (S-box block side)
// Revision : 1.0 - initial release
// ============================================================================
interface skinny_isbox8_dom1_ctrl_if;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] si0;
    logic [7:0] si1;
    logic [7:0] r;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] bo0;
    logic [7:0] bo1;

    modport master (
        output valid_i, si0, si1, r, ready_i,
        input  ready_o, valid_o, bo0, bo1
    );

    modport slave (
        input  valid_i, si0, si1, r, ready_i,
        output ready_o, valid_o, bo0, bo1
    );
endinterface
`default_nettype wire

// File: rtl/dom1_sbox8_cfn_lr.sv
`default_nettype none
// ============================================================================
// Module   : dom1_sbox8_cfn_lr
// Purpose  : First-order DOM-Indep gadget computing b = z ^ nor(p, q) on two
//            shares. nor(p,q) = (~p)&(~q); the inversion is applied to share 0
//            only. Cross-domain terms are refreshed with r and registered.
// Ports    : clk        - clock
//            i_p0/i_p1  - shares of p
//            i_q0/i_q1  - shares of q
//            i_z0/i_z1  - shares of z
//            i_r        - fresh mask bit
//            o_b0/o_b1  - shares of b
// Revision : 1.0 - initial release
// ============================================================================
module dom1_sbox8_cfn_lr (
    input  wire logic clk,
    input  wire logic i_p0,
    input  wire logic i_p1,
    input  wire logic i_q0,
    input  wire logic i_q1,
    input  wire logic i_z0,
    input  wire logic i_z1,
    input  wire logic i_r,
    output logic      o_b0,
    output logic      o_b1
);
    logic w_a0;
    logic w_c0;
    logic r_cross0;
    logic r_cross1;

    assign w_a0 = ~i_p0;
    assign w_c0 = ~i_q0;

    // Cross terms mix both domains, so they are masked and registered before
    // joining either output share.
    always_ff @(posedge clk) begin
        r_cross0 <= (w_a0 & i_q1) ^ i_r;
        r_cross1 <= (i_p1 & w_c0) ^ i_r;
    end

    assign o_b0 = i_z0 ^ (w_a0 & w_c0) ^ r_cross0;
    assign o_b1 = i_z1 ^ (i_p1 & i_q1) ^ r_cross1;
endmodule
`default_nettype wire

// File: rtl/skinny_isbox8_dom1_ctrl_net.sv
`default_nettype none
// ============================================================================
// Module   : skinny_isbox8_dom1_ctrl_net
// Purpose  : Four-layer masked S8^-1 network built from eight DOM gadgets.
//            Each mask bit feeds exactly one gadget. Outputs are correct
//            ISBOX8_DEPTH edges after the inputs become stable.
// Ports    : clk         - clock
//            i_x0/i_x1   - input shares
//            i_r         - fresh mask (bit k -> gadget k)
//            o_b0/o_b1   - output shares
// Revision : 1.0 - initial release
// ============================================================================
module skinny_isbox8_dom1_ctrl_net (
    input  wire logic       clk,
    input  wire logic [7:0] i_x0,
    input  wire logic [7:0] i_x1,
    input  wire logic [7:0] i_r,
    output logic      [7:0] o_b0,
    output logic      [7:0] o_b1
);
    // Scalar nets per output bit so later layers depend on distinct signals.
    logic w_b0_s0, w_b0_s1, w_b1_s0, w_b1_s1, w_b2_s0, w_b2_s1, w_b3_s0, w_b3_s1;
    logic w_b4_s0, w_b4_s1, w_b5_s0, w_b5_s1, w_b6_s0, w_b6_s1, w_b7_s0, w_b7_s1;

    // Layer 1
    dom1_sbox8_cfn_lr u_g_b2 (.clk(clk), .i_p0(i_x0[3]), .i_p1(i_x1[3]), .i_q0(i_x0[1]), .i_q1(i_x1[1]),
                              .i_z0(i_x0[0]), .i_z1(i_x1[0]), .i_r(i_r[0]), .o_b0(w_b2_s0), .o_b1(w_b2_s1));
    dom1_sbox8_cfn_lr u_g_b3 (.clk(clk), .i_p0(i_x0[7]), .i_p1(i_x1[7]), .i_q0(i_x0[6]), .i_q1(i_x1[6]),
                              .i_z0(i_x0[4]), .i_z1(i_x1[4]), .i_r(i_r[1]), .o_b0(w_b3_s0), .o_b1(w_b3_s1));
    dom1_sbox8_cfn_lr u_g_b7 (.clk(clk), .i_p0(i_x0[2]), .i_p1(i_x1[2]), .i_q0(i_x0[7]), .i_q1(i_x1[7]),
                              .i_z0(i_x0[1]), .i_z1(i_x1[1]), .i_r(i_r[2]), .o_b0(w_b7_s0), .o_b1(w_b7_s1));
    dom1_sbox8_cfn_lr u_g_b5 (.clk(clk), .i_p0(i_x0[6]), .i_p1(i_x1[6]), .i_q0(i_x0[5]), .i_q1(i_x1[5]),
                              .i_z0(i_x0[7]), .i_z1(i_x1[7]), .i_r(i_r[3]), .o_b0(w_b5_s0), .o_b1(w_b5_s1));
    // Layer 2
    dom1_sbox8_cfn_lr u_g_b1 (.clk(clk), .i_p0(i_x0[5]), .i_p1(i_x1[5]), .i_q0(w_b3_s0), .i_q1(w_b3_s1),
                              .i_z0(i_x0[3]), .i_z1(i_x1[3]), .i_r(i_r[4]), .o_b0(w_b1_s0), .o_b1(w_b1_s1));
    dom1_sbox8_cfn_lr u_g_b0 (.clk(clk), .i_p0(w_b3_s0), .i_p1(w_b3_s1), .i_q0(w_b2_s0), .i_q1(w_b2_s1),
                              .i_z0(i_x0[5]), .i_z1(i_x1[5]), .i_r(i_r[5]), .o_b0(w_b0_s0), .o_b1(w_b0_s1));
    // Layer 3
    dom1_sbox8_cfn_lr u_g_b6 (.clk(clk), .i_p0(w_b2_s0), .i_p1(w_b2_s1), .i_q0(w_b1_s0), .i_q1(w_b1_s1),
                              .i_z0(i_x0[2]), .i_z1(i_x1[2]), .i_r(i_r[6]), .o_b0(w_b6_s0), .o_b1(w_b6_s1));
    // Layer 4
    dom1_sbox8_cfn_lr u_g_b4 (.clk(clk), .i_p0(w_b7_s0), .i_p1(w_b7_s1), .i_q0(w_b6_s0), .i_q1(w_b6_s1),
                              .i_z0(i_x0[6]), .i_z1(i_x1[6]), .i_r(i_r[7]), .o_b0(w_b4_s0), .o_b1(w_b4_s1));

    assign o_b0 = {w_b7_s0, w_b6_s0, w_b5_s0, w_b4_s0, w_b3_s0, w_b2_s0, w_b1_s0, w_b0_s0};
    assign o_b1 = {w_b7_s1, w_b6_s1, w_b5_s1, w_b4_s1, w_b3_s1, w_b2_s1, w_b1_s1, w_b0_s1};
endmodule
`default_nettype wire

// File: rtl/skinny_isbox8_dom1_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : skinny_isbox8_dom1_ctrl
// Purpose  : First-order masked SKINNY S8^-1 with valid/ready control. Latches
//            the input shares and mask on accept and holds them for SETTLE
//            edges while the non-pipelined network settles, then presents the
//            result until the consumer takes it.
// Params   : SETTLE - edges from accept to valid_o (>= ISBOX8_DEPTH)
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - slave modport: valid_i/ready_o/si0/si1/r in,
//                     valid_o/ready_i/bo0/bo1 out
// Macro    : SKINNY_ISBOX8_OUT_GATE_EN - force bo0/bo1 to 0 while valid_o=0
// Revision : 1.0 - initial release
// ============================================================================
module skinny_isbox8_dom1_ctrl
    import skinny_dom1_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    skinny_isbox8_dom1_ctrl_if.slave bus
);
    if (SETTLE < ISBOX8_DEPTH) begin : g_settle_check
        $error("SETTLE must be at least ISBOX8_DEPTH");
    end

    localparam int                 c_CNT_W = $clog2(SETTLE);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SETTLE - 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ready;
    logic               r_valid;
    logic [7:0]         r_xs0;
    logic [7:0]         r_xs1;
    logic [7:0]         r_xr;
    logic               w_accept;
    logic [7:0]         w_b0;
    logic [7:0]         w_b1;

    assign w_accept = bus.valid_i & r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BUSY;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Unreset share/mask latches: loaded only on accept, then frozen so the
    // network sees one stable operand set for the whole settle window.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_xs0 <= bus.si0;
            r_xs1 <= bus.si1;
            r_xr  <= bus.r;
        end
    end

    skinny_isbox8_dom1_ctrl_net u_net (
        .clk  (clk),
        .i_x0 (r_xs0),
        .i_x1 (r_xs1),
        .i_r  (r_xr),
        .o_b0 (w_b0),
        .o_b1 (w_b1)
    );

    assign bus.ready_o = r_ready;
    assign bus.valid_o = r_valid;

`ifdef SKINNY_ISBOX8_OUT_GATE_EN
    // Keep settling intermediate shares off the output bus.
    assign bus.bo0 = r_valid ? w_b0 : 8'h00;
    assign bus.bo1 = r_valid ? w_b1 : 8'h00;
`else
    assign bus.bo0 = w_b0;
    assign bus.bo1 = w_b1;
`endif
endmodule
`default_nettype wire

// File: tb/tb_skinny_isbox8_dom1_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_skinny_isbox8_dom1_ctrl
// Purpose  : Self-checking bench for skinny_isbox8_dom1_ctrl. Reference
//            inverse S-box is a lookup table built by inverting a
//            MIX/PERMUTE model of the forward SKINNY S8.
// Macro    : SKINNY_ISBOX8_OUT_GATE_EN - enables output-gating checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_skinny_isbox8_dom1_ctrl;
    import skinny_dom1_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    skinny_isbox8_dom1_ctrl_if bus ();

    skinny_isbox8_dom1_ctrl #(.SETTLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] m;
        logic [7:0] exp;
    } vec_t;

    logic [7:0] inv_tab [256];

    // Forward SKINNY S8: four NOR-mix rounds with bit permutations between
    // them, followed by a final swap of bits 1 and 2.
    function automatic logic [7:0] fwd_model(input logic [7:0] x);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < 4; i++) begin
            v = v ^ ((~(((v >> 1) | v) >> 2)) & 8'h11);
            if (i < 3)
                v = ((v & 8'h01) << 2) | ((v & 8'h06) << 5) | ((v & 8'h20) >> 5) |
                    ((v & 8'hC8) >> 2) | ((v & 8'h10) >> 1);
        end
        return (v & 8'hF9) | ((v >> 1) & 8'h02) | ((v << 1) & 8'h04);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < 40) begin
`ifdef SKINNY_ISBOX8_OUT_GATE_EN
            check8("gated_bo0", bus.bo0, 8'h00);
            check8("gated_bo1", bus.bo1, 8'h00);
`endif
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] m,
                          output logic [7:0] res);
        int lat;
        @(negedge clk);
        check8("ready_before_accept", {7'd0, bus.ready_o}, 8'h01);
        bus.si0 = s0; bus.si1 = s1; bus.r = m; bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.si0 = 8'($urandom); bus.si1 = 8'($urandom); bus.r = 8'($urandom);
        wait_valid(lat);
        check8("latency", 8'(lat), 8'd4);
        res = bus.bo0 ^ bus.bo1;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t       vecs [6];
        logic [7:0] res, y, s0, m, x;
        int         lat;

        for (int i = 0; i < 256; i++) inv_tab[fwd_model(8'(i))] = 8'(i);

        vecs[0] = '{8'h3A, 8'h5F, 8'hA5, 8'h00};
        vecs[1] = '{8'h00, 8'h4C, 8'h00, 8'h01};
        vecs[2] = '{8'hA3, 8'h5C, 8'($urandom), 8'hFF};
        vecs[3] = '{8'h5C, 8'hA3, 8'hFF, 8'hFF};
        vecs[4] = '{8'h00, 8'h65, 8'hFF, 8'h00};
        vecs[5] = '{8'hFF, 8'hB3, 8'h3C, 8'h01};

        bus.valid_i = 1'b0; bus.ready_i = 1'b0;
        bus.si0 = 8'h00; bus.si1 = 8'h00; bus.r = 8'h00;
        rst_n = 1'b0;
        #12;
        check8("reset_ready_o", {7'd0, bus.ready_o}, 8'h01);
        check8("reset_valid_o", {7'd0, bus.valid_o}, 8'h00);
        rst_n = 1'b1;

        // Package reference functions against the bench model.
        for (int i = 0; i < 256; i++) begin
            check8($sformatf("pkg_inv y=%02h", i), skinny_isbox8_ref(8'(i)), inv_tab[i]);
            check8($sformatf("pkg_fwd x=%02h", i), skinny_sbox8_ref(8'(i)), fwd_model(8'(i)));
        end

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].s0, vecs[i].s1, vecs[i].m, res);
            check8($sformatf("vec%0d", i), res, vecs[i].exp);
        end

        // Exhaustive y with random share splits and masks
        for (int yy = 0; yy < 256; yy++) begin
            for (int k = 0; k < 16; k++) begin
                y  = 8'(yy);
                s0 = 8'($urandom);
                m  = 8'($urandom);
                run_op(s0, s0 ^ y, m, res);
                check8($sformatf("exh y=%02h", y), res, inv_tab[y]);
            end
        end

        // Forward then inverse roundtrip
        for (int k = 0; k < 16; k++) begin
            x  = 8'($urandom);
            y  = skinny_sbox8_ref(x);
            s0 = 8'($urandom);
            run_op(s0, s0 ^ y, 8'($urandom), res);
            check8("roundtrip", res, x);
        end

        // Inputs churn during BUSY; consumer stalls 10 cycles in DONE.
        @(negedge clk);
        bus.si0 = 8'h12; bus.si1 = 8'h12 ^ 8'h4C; bus.r = 8'h5A; bus.valid_i = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < 40) begin
            bus.si0 = 8'($urandom); bus.si1 = 8'($urandom); bus.r = 8'($urandom);
            check8("busy_ready_o", {7'd0, bus.ready_o}, 8'h00);
            @(posedge clk); #1;
            lat++;
        end
        check8("churn_latency", 8'(lat), 8'd4);
        for (int c = 0; c < 10; c++) begin
            bus.si0 = 8'($urandom); bus.si1 = 8'($urandom); bus.r = 8'($urandom);
            @(posedge clk); #1;
            check8("stall_valid_o", {7'd0, bus.valid_o}, 8'h01);
            check8("stall_ready_o", {7'd0, bus.ready_o}, 8'h00);
            check8("stall_result", bus.bo0 ^ bus.bo1, 8'h01);
        end
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        check8("release_valid_o", {7'd0, bus.valid_o}, 8'h00);
        check8("release_ready_o", {7'd0, bus.ready_o}, 8'h01);

        // Reset while BUSY with cnt=2
        @(negedge clk);
        bus.si0 = 8'h77; bus.si1 = 8'h77 ^ 8'h65; bus.r = 8'hC3; bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check8("rst_busy_valid_o", {7'd0, bus.valid_o}, 8'h00);
        check8("rst_busy_ready_o", {7'd0, bus.ready_o}, 8'h01);
        #1 rst_n = 1'b1;
        run_op(8'h9C, 8'h9C ^ 8'hFF, 8'h18, res);
        check8("after_rst_busy", res, 8'hFF);

        // Reset while DONE discards the pending result
        @(negedge clk);
        bus.si0 = 8'h21; bus.si1 = 8'h21 ^ 8'h4C; bus.r = 8'h0F; bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        wait_valid(lat);
        check8("done_valid_o", {7'd0, bus.valid_o}, 8'h01);
        rst_n = 1'b0;
        #1;
        check8("rst_done_valid_o", {7'd0, bus.valid_o}, 8'h00);
        check8("rst_done_ready_o", {7'd0, bus.ready_o}, 8'h01);
        #1 rst_n = 1'b1;
        run_op(8'h40, 8'h40 ^ 8'h65, 8'hE7, res);
        check8("after_rst_done", res, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
